pe_addsub_pipe: RTL and testbench

//  Parametrised modular add/sub butterfly PE for the NTT/INTT datapath (Kyber q=3329 by default).

---
 rtl/pe_addsub_pipe_pkg.sv | 20 ++
 rtl/pe_addsub_pipe_if.sv | 29 ++
 rtl/pe_addsub_pipe_mod_addsub_half.sv | 36 +++
 rtl/pe_addsub_pipe.sv | 131 +++++++++++++
 tb/tb_pe_addsub_pipe.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/pe_addsub_pipe_pkg.sv
// Shared constants and mode encodings for the NTT/INTT datapath.
// Used by the add/sub PE, the multiplier PE and the NTT controller.
package pe_addsub_pipe_pkg;

    localparam int DATA_WIDTH_DEF = 12;
    localparam int MODULUS_DEF    = 3329;

    typedef enum logic [1:0] {
        MODE_ADDSUB  = 2'b00,
        MODE_HALF    = 2'b01,
        MODE_BYP     = 2'b10,
        MODE_BYP_RSV = 2'b11
    } mode_e;

    // Both upper encodings pass the operands straight through.
    function automatic logic is_bypass(input logic [1:0] mode);
        return mode[1];
    endfunction

endpackage

// File: rtl/pe_addsub_pipe_if.sv
// Handshake and data bundle between a butterfly PE and its producer/consumer.
interface pe_addsub_pipe_if
    import pe_addsub_pipe_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
);

    logic                  in_valid;
    logic                  in_ready;
    logic [1:0]            mode;
    logic [DATA_WIDTH-1:0] u;
    logic [DATA_WIDTH-1:0] v;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] bf_upper;
    logic [DATA_WIDTH-1:0] bf_lower;
    logic                  range_err;

    modport master (
        output in_valid, mode, u, v, out_ready,
        input  in_ready, out_valid, bf_upper, bf_lower, range_err
    );

    modport slave (
        input  in_valid, mode, u, v, out_ready,
        output in_ready, out_valid, bf_upper, bf_lower, range_err
    );

endinterface

// File: rtl/pe_addsub_pipe_mod_addsub_half.sv
// Combinational modular add and subtract with optional halving (multiply by 2^-1 mod q).
module mod_addsub_half #(
    parameter int DATA_WIDTH = 12,
    parameter int MODULUS    = 3329
) (
    input  logic [DATA_WIDTH-1:0] u,
    input  logic [DATA_WIDTH-1:0] v,
    input  logic                  halve,
    output logic [DATA_WIDTH-1:0] sum_out,
    output logic [DATA_WIDTH-1:0] diff_out
);

    localparam logic [DATA_WIDTH:0] Q = (DATA_WIDTH+1)'(MODULUS);

    logic [DATA_WIDTH:0] sum_raw;
    logic [DATA_WIDTH:0] diff_raw;
    logic [DATA_WIDTH:0] sum_red;
    logic [DATA_WIDTH:0] diff_red;

    // An odd residue becomes even after adding q, so the shift stays exact mod q.
    function automatic logic [DATA_WIDTH-1:0] half_mod(input logic [DATA_WIDTH:0] x);
        logic [DATA_WIDTH:0] t;
        t = x[0] ? x + Q : x;
        return t[DATA_WIDTH:1];
    endfunction

    always_comb begin
        sum_raw  = {1'b0, u} + {1'b0, v};
        diff_raw = {1'b0, u} - {1'b0, v};
        sum_red  = (sum_raw >= Q) ? sum_raw - Q : sum_raw;
        diff_red = diff_raw[DATA_WIDTH] ? diff_raw + Q : diff_raw;
        sum_out  = halve ? half_mod(sum_red)  : sum_red[DATA_WIDTH-1:0];
        diff_out = halve ? half_mod(diff_red) : diff_red[DATA_WIDTH-1:0];
    end

endmodule

// File: rtl/pe_addsub_pipe.sv
// Elastic add/sub butterfly PE: PRE_STAGES operand registers, modular add/sub/halve,
// then POST_STAGES result registers, all advancing together under one global enable.
module pe_addsub_pipe
    import pe_addsub_pipe_pkg::*;
#(
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int MODULUS     = MODULUS_DEF,
    parameter int PRE_STAGES  = 3,
    parameter int POST_STAGES = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    pe_addsub_pipe_if.slave      bus
);

    localparam int                  L = PRE_STAGES + POST_STAGES;
    localparam logic [DATA_WIDTH:0] Q = (DATA_WIDTH+1)'(MODULUS);

    logic                  valid_q [L];
    logic                  valid_d [L];
    logic [1:0]            mode_q  [PRE_STAGES];
    logic [1:0]            mode_d  [PRE_STAGES];
    logic [DATA_WIDTH-1:0] u_q     [PRE_STAGES];
    logic [DATA_WIDTH-1:0] u_d     [PRE_STAGES];
    logic [DATA_WIDTH-1:0] v_q     [PRE_STAGES];
    logic [DATA_WIDTH-1:0] v_d     [PRE_STAGES];
    logic [DATA_WIDTH-1:0] upper_q [POST_STAGES];
    logic [DATA_WIDTH-1:0] upper_d [POST_STAGES];
    logic [DATA_WIDTH-1:0] lower_q [POST_STAGES];
    logic [DATA_WIDTH-1:0] lower_d [POST_STAGES];
    logic                  range_err_q;
    logic                  range_err_d;

    logic                  adv;
    logic                  accept;
    logic                  operand_bad;
    logic                  halve;
    logic [DATA_WIDTH-1:0] sum_res;
    logic [DATA_WIDTH-1:0] diff_res;
    logic [DATA_WIDTH-1:0] stage_upper;
    logic [DATA_WIDTH-1:0] stage_lower;

    // A single enable keeps every stage in lockstep; the output register only frees up when drained.
    assign adv          = ~valid_q[L-1] | bus.out_ready;
    assign bus.in_ready = rst & adv;
    assign accept       = bus.in_valid & bus.in_ready;
    assign operand_bad  = ({1'b0, bus.u} >= Q) | ({1'b0, bus.v} >= Q);
    assign halve        = (mode_q[PRE_STAGES-1] == MODE_HALF);

    mod_addsub_half #(
        .DATA_WIDTH (DATA_WIDTH),
        .MODULUS    (MODULUS)
    ) u_core (
        .u        (u_q[PRE_STAGES-1]),
        .v        (v_q[PRE_STAGES-1]),
        .halve    (halve),
        .sum_out  (sum_res),
        .diff_out (diff_res)
    );

    always_comb begin
        stage_upper = diff_res;
        stage_lower = sum_res;
        if (is_bypass(mode_q[PRE_STAGES-1])) begin
            stage_upper = u_q[PRE_STAGES-1];
            stage_lower = v_q[PRE_STAGES-1];
        end
    end

    always_comb begin
        valid_d     = valid_q;
        mode_d      = mode_q;
        u_d         = u_q;
        v_d         = v_q;
        upper_d     = upper_q;
        lower_d     = lower_q;
        range_err_d = range_err_q | (accept & operand_bad);
        if (adv) begin
            valid_d[0] = accept;
            mode_d[0]  = bus.mode;
            u_d[0]     = bus.u;
            v_d[0]     = bus.v;
            for (int i = 1; i < PRE_STAGES; i++) begin
                mode_d[i] = mode_q[i-1];
                u_d[i]    = u_q[i-1];
                v_d[i]    = v_q[i-1];
            end
            for (int i = 1; i < L; i++) begin
                valid_d[i] = valid_q[i-1];
            end
            upper_d[0] = stage_upper;
            lower_d[0] = stage_lower;
            for (int i = 1; i < POST_STAGES; i++) begin
                upper_d[i] = upper_q[i-1];
                lower_d[i] = lower_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < L; i++) begin
                valid_q[i] <= 1'b0;
            end
            for (int i = 0; i < PRE_STAGES; i++) begin
                mode_q[i] <= '0;
                u_q[i]    <= '0;
                v_q[i]    <= '0;
            end
            for (int i = 0; i < POST_STAGES; i++) begin
                upper_q[i] <= '0;
                lower_q[i] <= '0;
            end
            range_err_q <= 1'b0;
        end else begin
            valid_q     <= valid_d;
            mode_q      <= mode_d;
            u_q         <= u_d;
            v_q         <= v_d;
            upper_q     <= upper_d;
            lower_q     <= lower_d;
            range_err_q <= range_err_d;
        end
    end

    assign bus.out_valid = valid_q[L-1];
    assign bus.bf_upper  = upper_q[POST_STAGES-1];
    assign bus.bf_lower  = lower_q[POST_STAGES-1];
    assign bus.range_err = range_err_q;

endmodule

// File: tb/tb_pe_addsub_pipe.sv
// Directed vector table plus stall, range-error and reset sequences for pe_addsub_pipe.
module tb_pe_addsub_pipe;
    import pe_addsub_pipe_pkg::*;

    localparam int DW = 12;
    localparam int Q  = 3329;
    localparam int L  = 6;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pe_addsub_pipe_if #(.DATA_WIDTH(DW)) bus();

    pe_addsub_pipe #(
        .DATA_WIDTH (DW),
        .MODULUS    (Q),
        .PRE_STAGES (3),
        .POST_STAGES(3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int mode;
        int u;
        int v;
        int exp_upper;
        int exp_lower;
    } vec_t;

    typedef struct {
        int upper;
        int lower;
    } res_t;

    vec_t vecs [12];
    res_t exp_q [$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check_output(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    function automatic int half_ref(input int x);
        return (x % 2 == 0) ? x / 2 : (x + Q) / 2;
    endfunction

    function automatic res_t ref_model(input int mode, input int u, input int v);
        res_t r;
        r.upper = (u - v + Q) % Q;
        r.lower = (u + v) % Q;
        if (mode == 1) begin
            r.upper = half_ref(r.upper);
            r.lower = half_ref(r.lower);
        end else if (mode >= 2) begin
            r.upper = u;
            r.lower = v;
        end
        return r;
    endfunction

    // Sends one beat into an idle pipe and reports when and what comes out.
    task automatic apply_stimulus(input int mode, input int u, input int v,
                                  output int upper, output int lower, output int lat);
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.mode      = 2'(mode);
        bus.u         = DW'(u);
        bus.v         = DW'(v);
        bus.out_ready = 1'b1;
        lat   = -1;
        upper = -1;
        lower = -1;
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            #1;
            if (bus.out_valid) begin
                lat   = n;
                upper = int'(bus.bf_upper);
                lower = int'(bus.bf_lower);
                break;
            end
        end
    endtask

    int up, lo, lat;
    int s_mode [20];
    int s_u    [20];
    int s_v    [20];

    initial begin
        vecs[0]  = '{0, 3000,  500, 2500,  171};
        vecs[1]  = '{0,    5,   10, 3324,   15};
        vecs[2]  = '{0,    0,    0,    0,    0};
        vecs[3]  = '{1, 3000,  500, 1250, 1750};
        vecs[4]  = '{2, 3000,  500, 3000,  500};
        vecs[5]  = '{3,    7,    9,    7,    9};
        vecs[6]  = '{0, 3328, 3328,    0, 3327};
        vecs[7]  = '{0,    0, 3328,    1, 3328};
        vecs[8]  = '{1,    0, 3328, 1665, 1664};
        vecs[9]  = '{1,    1,    0, 1665, 1665};
        vecs[10] = '{0, 1664, 1665, 3328,    0};
        vecs[11] = '{1, 1664, 1665, 1664,    0};

        rst           = 1'b0;
        bus.in_valid  = 1'b0;
        bus.mode      = 2'b00;
        bus.u         = '0;
        bus.v         = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check_output("reset out_valid", int'(bus.out_valid), 0);
        check_output("reset in_ready", int'(bus.in_ready), 0);
        check_output("reset range_err", int'(bus.range_err), 0);
        check_output("reset bf_upper", int'(bus.bf_upper), 0);
        check_output("reset bf_lower", int'(bus.bf_lower), 0);
        rst = 1'b1;
        #1;
        check_output("in_ready after reset", int'(bus.in_ready), 1);

        for (int i = 0; i < 12; i++) begin
            apply_stimulus(vecs[i].mode, vecs[i].u, vecs[i].v, up, lo, lat);
            check_output($sformatf("vec%0d latency", i), lat, L);
            check_output($sformatf("vec%0d bf_upper", i), up, vecs[i].exp_upper);
            check_output($sformatf("vec%0d bf_lower", i), lo, vecs[i].exp_lower);
        end

        // Random backpressure stream: ordering, completeness and hold-while-stalled.
        begin
            int   idx = 0;
            int   rcv = 0;
            logic stalled = 1'b0;
            int   prev_up = 0;
            int   prev_lo = 0;
            int   stable_bad = 0;
            for (int i = 0; i < 20; i++) begin
                s_mode[i] = $urandom_range(0, 3);
                s_u[i]    = $urandom_range(0, Q - 1);
                s_v[i]    = $urandom_range(0, Q - 1);
            end
            for (int cyc = 0; cyc < 600 && !(idx == 20 && exp_q.size() == 0); cyc++) begin
                @(negedge clk);
                bus.in_valid  = (idx < 20);
                if (idx < 20) begin
                    bus.mode = 2'(s_mode[idx]);
                    bus.u    = DW'(s_u[idx]);
                    bus.v    = DW'(s_v[idx]);
                end
                bus.out_ready = 1'($urandom_range(0, 1));
                #1;
                if (stalled) begin
                    if (!bus.out_valid || int'(bus.bf_upper) != prev_up || int'(bus.bf_lower) != prev_lo)
                        stable_bad++;
                end
                if (bus.out_valid && bus.out_ready) begin
                    if (exp_q.size() == 0) begin
                        check_output("stream unexpected beat", 1, 0);
                    end else begin
                        res_t e;
                        e = exp_q.pop_front();
                        check_output($sformatf("stream beat%0d upper", rcv), int'(bus.bf_upper), e.upper);
                        check_output($sformatf("stream beat%0d lower", rcv), int'(bus.bf_lower), e.lower);
                    end
                    rcv++;
                end
                if (bus.in_valid && bus.in_ready) begin
                    exp_q.push_back(ref_model(s_mode[idx], s_u[idx], s_v[idx]));
                    idx++;
                end
                stalled = bus.out_valid && !bus.out_ready;
                prev_up = int'(bus.bf_upper);
                prev_lo = int'(bus.bf_lower);
            end
            bus.in_valid  = 1'b0;
            bus.out_ready = 1'b1;
            check_output("stream beats sent", idx, 20);
            check_output("stream beats received", rcv, 20);
            check_output("stream stall stability violations", stable_bad, 0);
        end

        // Out-of-range operand sets the sticky flag without disturbing later beats.
        begin
            int seen = 0;
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.mode     = 2'b00;
            bus.u        = DW'(3329);
            bus.v        = '0;
            #1;
            check_output("range beat in_ready", int'(bus.in_ready), 1);
            @(negedge clk);
            bus.in_valid = 1'b0;
            #1;
            check_output("range_err set", int'(bus.range_err), 1);
            for (int n = 0; n < 20 && seen == 0; n++) begin
                @(negedge clk);
                #1;
                if (bus.out_valid) seen = 1;
            end
            check_output("range beat drained", seen, 1);
            apply_stimulus(0, 3000, 500, up, lo, lat);
            check_output("post-range upper", up, 2500);
            check_output("post-range lower", lo, 171);
            check_output("range_err sticky", int'(bus.range_err), 1);
        end

        // Reset with beats in flight flushes them and clears the flag.
        begin
            int stale = 0;
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                bus.in_valid = 1'b1;
                bus.mode     = 2'b00;
                bus.u        = DW'(100 + i);
                bus.v        = DW'(4000);
            end
            @(negedge clk);
            bus.in_valid = 1'b0;
            rst          = 1'b0;
            @(negedge clk);
            #1;
            check_output("flush out_valid", int'(bus.out_valid), 0);
            check_output("flush range_err", int'(bus.range_err), 0);
            check_output("flush in_ready low", int'(bus.in_ready), 0);
            rst = 1'b1;
            #1;
            check_output("flush in_ready high", int'(bus.in_ready), 1);
            for (int n = 0; n < 12; n++) begin
                @(negedge clk);
                #1;
                if (bus.out_valid) stale++;
            end
            check_output("flush stale beats", stale, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
